// File: rtl/control_seq.sv
`timescale 1ns/1ps
// control_seq -- five-phase instruction sequencer with debounced run/stop
// and (optionally) single-step buttons.
//
// Optional feature macro: CTRL_STEP_EN (adds the step port and single-step logic).
//
// Ports
//   clock, reset           : system clock, asynchronous active-low reset
//   exec                   : run/stop button (asynchronous, bouncy)
//   step                   : single-step button (only with CTRL_STEP_EN)
//   instruction[15:0]      : current IR contents
//   SZCV[3:0]              : flags {S,Z,C,V}
//   in_valid / in_ack      : external input handshake for the IN instruction
//   phase[4:0]             : one-hot phase, bit0 = P1 .. bit4 = P5
//   systemRunning, halted  : run status
//   updateIR/SZCV/PC       : register enables for P1 / P3 / P5
//   addressSrc .. memToReg : datapath controls
//   ALUOp[3:0]             : ALU operation
//
// Opcode map assumed: [15:14]=00 LD, 01 ST, 10 immediate/branch group
// (sub-op in [13:11], branch condition in [10:8]), 11 ALU group (op in [7:4]).
module control_seq #(
   parameter int DEBOUNCE_LEN = 16,
   parameter int DBW          = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        exec,
`ifdef CTRL_STEP_EN
   input  logic        step,
`endif
   input  logic [15:0] instruction,
   input  logic [3:0]  SZCV,
   input  logic        in_valid,
   output logic        in_ack,
   output logic [4:0]  phase,
   output logic        systemRunning,
   output logic        halted,
   output logic        updateIR,
   output logic        updateSZCV,
   output logic        updatePC,
   output logic        addressSrc,
   output logic        regDst,
   output logic        ALUSrcAR,
   output logic        ALUSrcBR,
   output logic        DRSrc,
   output logic        outputEnable,
   output logic        inputEnable,
   output logic        memWrite,
   output logic        branch,
   output logic        regWrite,
   output logic        memToReg,
   output logic [3:0]  ALUOp
);

`ifdef CTRL_STEP_EN
   localparam int NB = 2;   // button 0 = exec, button 1 = step
`else
   localparam int NB = 1;
`endif
   localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_LEN - 1);

   typedef enum logic [4:0] {
      P1 = 5'b00001,
      P2 = 5'b00010,
      P3 = 5'b00100,
      P4 = 5'b01000,
      P5 = 5'b10000
   } phase_e;

   logic [NB-1:0]  btn_raw;
   logic [NB-1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
   logic [NB-1:0]  stab_q, stab_d, rise_q, rise_d;
   logic [DBW-1:0] cnt_q [NB];
   logic [DBW-1:0] cnt_d [NB];
   phase_e         phase_q, phase_d;
   logic           run_q, run_d, halted_q, halted_d, stop_q, stop_d;
   logic           exec_rise;
   logic           is_ld, is_st, is_li, is_b, is_bcc, is_alu, is_in, is_out, is_halt;
   logic           writer, take, s_xor_v;
   logic           unused_bits;

`ifdef CTRL_STEP_EN
   logic           step_rise;
   assign btn_raw   = {step, exec};
   assign step_rise = rise_q[1];
`else
   assign btn_raw   = exec;
`endif
   assign exec_rise   = rise_q[0];
   assign unused_bits = ^{SZCV[1], instruction[3:0]};

   // Synchroniser + debouncer: the counter tracks how many consecutive
   // cycles the synchronised level has differed from the accepted level.
   // rise_q is a one-cycle pulse registered when a new high level is accepted.
   always_comb begin
      sync1_d = btn_raw;
      sync2_d = sync1_q;
      stab_d  = stab_q;
      rise_d  = '0;
      for (int b = 0; b < NB; b++) begin
         cnt_d[b] = '0;
         if (sync2_q[b] != stab_q[b]) begin
            if (cnt_q[b] == DB_LAST) begin
               stab_d[b] = sync2_q[b];
               rise_d[b] = sync2_q[b];
            end else begin
               cnt_d[b] = cnt_q[b] + 1'b1;
            end
         end
      end
   end

   // Instruction decode
   always_comb begin
      is_ld   = (instruction[15:14] == 2'b00);
      is_st   = (instruction[15:14] == 2'b01);
      is_li   = (instruction[15:11] == 5'b10000);
      is_b    = (instruction[15:11] == 5'b10100);
      is_bcc  = (instruction[15:11] == 5'b10111);
      is_alu  = (instruction[15:14] == 2'b11);
      is_in   = is_alu && (instruction[7:4] == 4'b1100);
      is_out  = is_alu && (instruction[7:4] == 4'b1101);
      is_halt = is_alu && (instruction[7:4] == 4'b1111);
      // ALU writers: ADD..XOR (0000-0100), MOV (0110), shifts (10xx), IN (1100)
      writer  = is_ld || is_li ||
                (is_alu && ((instruction[7:4] <= 4'b0100) ||
                            (instruction[7:4] == 4'b0110) ||
                            (instruction[7:6] == 2'b10)   ||
                            (instruction[7:4] == 4'b1100)));
      s_xor_v = SZCV[3] ^ SZCV[0];
      take    = is_b;
      if (is_bcc) begin
         case (instruction[10:8])
            3'b000:  take = SZCV[2];
            3'b001:  take = s_xor_v;
            3'b010:  take = SZCV[2] | s_xor_v;
            3'b011:  take = ~SZCV[2];
            default: take = 1'b0;
         endcase
      end
   end

   // Phase sequencer. Stop requests (and single step, which starts with a
   // stop already pending) only take effect at the end of P5.
   always_comb begin
      phase_d  = phase_q;
      run_d    = run_q;
      halted_d = halted_q;
      stop_d   = stop_q;
      if (!run_q) begin
         phase_d = P1;
         if (exec_rise) begin
            run_d    = 1'b1;
            halted_d = 1'b0;
            stop_d   = 1'b0;
         end
`ifdef CTRL_STEP_EN
         else if (step_rise) begin
            run_d    = 1'b1;
            halted_d = 1'b0;
            stop_d   = 1'b1;
         end
`endif
      end else begin
         if (exec_rise) stop_d = 1'b1;
         case (phase_q)
            P1: phase_d = P2;
            P2: phase_d = P3;
            P3: phase_d = P4;
            P4: if (!(is_in && !in_valid)) phase_d = P5;
            P5: begin
               phase_d = P1;
               // HALT and a pending stop collapse into one stop
               if (is_halt || stop_q || exec_rise) begin
                  run_d  = 1'b0;
                  stop_d = 1'b0;
                  if (is_halt) halted_d = 1'b1;
               end
            end
            default: phase_d = P1;
         endcase
      end
   end

   // Outputs
   always_comb begin
      phase         = phase_q;
      systemRunning = run_q;
      halted        = halted_q;
      in_ack        = run_q && (phase_q == P4) && is_in && in_valid;
      updateIR      = run_q && (phase_q == P1);
      updateSZCV    = run_q && (phase_q == P3);
      updatePC      = run_q && (phase_q == P5) && !is_halt;
      addressSrc    = run_q && (phase_q == P4);
      memWrite      = run_q && (phase_q == P4) && is_st;
      regWrite      = run_q && (phase_q == P5) && writer;
      branch        = run_q && (phase_q == P5) && take;
      outputEnable  = run_q && (phase_q == P3) && is_out;
      regDst        = is_ld;
      ALUSrcAR      = is_alu;
      ALUSrcBR      = (instruction[15:14] != 2'b10);
      DRSrc         = is_alu && instruction[7];
      inputEnable   = is_in;
      memToReg      = is_ld || is_in;
      ALUOp         = 4'b0000;
      if (is_alu)     ALUOp = instruction[7:4];
      else if (is_li) ALUOp = 4'b0110;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         stab_q   <= '0;
         rise_q   <= '0;
         for (int b = 0; b < NB; b++) cnt_q[b] <= '0;
         phase_q  <= P1;
         run_q    <= 1'b0;
         halted_q <= 1'b0;
         stop_q   <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stab_q   <= stab_d;
         rise_q   <= rise_d;
         for (int b = 0; b < NB; b++) cnt_q[b] <= cnt_d[b];
         phase_q  <= phase_d;
         run_q    <= run_d;
         halted_q <= halted_d;
         stop_q   <= stop_d;
      end
   end

endmodule

// File: tb/tb_control_seq.sv
`timescale 1ns/1ps
// Testbench for control_seq: directed scenarios plus randomized stimulus,
// checked every cycle against an instruction-level behavioural model.
module tb_control_seq;

   localparam int LEN = 16;
`ifdef CTRL_STEP_EN
   localparam bit STEP_EN = 1'b1;
`else
   localparam bit STEP_EN = 1'b0;
`endif

   logic        clock, reset, exec, step_drv, in_valid;
   logic [15:0] instruction;
   logic [3:0]  SZCV;
   logic        in_ack, systemRunning, halted;
   logic [4:0]  phase;
   logic        updateIR, updateSZCV, updatePC, addressSrc, regDst, ALUSrcAR, ALUSrcBR;
   logic        DRSrc, outputEnable, inputEnable, memWrite, branch, regWrite, memToReg;
   logic [3:0]  ALUOp;

   int n_cmp  = 0;
   int n_fail = 0;

   control_seq #(.DEBOUNCE_LEN(LEN), .DBW(16)) dut (
      .clock(clock), .reset(reset), .exec(exec),
`ifdef CTRL_STEP_EN
      .step(step_drv),
`endif
      .instruction(instruction), .SZCV(SZCV), .in_valid(in_valid), .in_ack(in_ack),
      .phase(phase), .systemRunning(systemRunning), .halted(halted),
      .updateIR(updateIR), .updateSZCV(updateSZCV), .updatePC(updatePC),
      .addressSrc(addressSrc), .regDst(regDst), .ALUSrcAR(ALUSrcAR), .ALUSrcBR(ALUSrcBR),
      .DRSrc(DRSrc), .outputEnable(outputEnable), .inputEnable(inputEnable),
      .memWrite(memWrite), .branch(branch), .regWrite(regWrite), .memToReg(memToReg),
      .ALUOp(ALUOp)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- behavioural model ----------------
   typedef enum int {M_LD, M_ST, M_LI, M_B, M_BE, M_BLT, M_BLE, M_BNE,
                     M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_CMP, M_MOV,
                     M_SLL, M_SLR, M_SRL, M_SRA, M_IN, M_OUT, M_HALT, M_NONE} mnem_e;

   function automatic mnem_e mnem(input logic [15:0] ir);
      casez (ir)
         16'b00??_????_????_????: return M_LD;
         16'b01??_????_????_????: return M_ST;
         16'b1000_0???_????_????: return M_LI;
         16'b1010_0???_????_????: return M_B;
         16'b1011_1000_????_????: return M_BE;
         16'b1011_1001_????_????: return M_BLT;
         16'b1011_1010_????_????: return M_BLE;
         16'b1011_1011_????_????: return M_BNE;
         16'b11??_????_0000_????: return M_ADD;
         16'b11??_????_0001_????: return M_SUB;
         16'b11??_????_0010_????: return M_AND;
         16'b11??_????_0011_????: return M_OR;
         16'b11??_????_0100_????: return M_XOR;
         16'b11??_????_0101_????: return M_CMP;
         16'b11??_????_0110_????: return M_MOV;
         16'b11??_????_1000_????: return M_SLL;
         16'b11??_????_1001_????: return M_SLR;
         16'b11??_????_1010_????: return M_SRL;
         16'b11??_????_1011_????: return M_SRA;
         16'b11??_????_1100_????: return M_IN;
         16'b11??_????_1101_????: return M_OUT;
         16'b11??_????_1111_????: return M_HALT;
         default:                 return M_NONE;
      endcase
   endfunction

   // Button model: [0]=exec, [1]=step. runlen counts identical consecutive
   // synchronised samples; a level is accepted once it has lasted LEN cycles.
   bit m_p1 [2], m_p2 [2], m_last [2], m_stab [2], m_rise [2];
   int m_runlen [2];
   bit m_run = 0, m_halt = 0, m_stop = 0;
   int m_ph = 1;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_run = 0; m_halt = 0; m_stop = 0; m_ph = 1;
         for (int b = 0; b < 2; b++) begin
            m_p1[b] = 0; m_p2[b] = 0; m_last[b] = 0; m_stab[b] = 0; m_rise[b] = 0; m_runlen[b] = 0;
         end
      end else begin
         automatic mnem_e mn = mnem(instruction);
         automatic bit    er = m_rise[0];
         automatic bit    sr = m_rise[1];
         automatic bit    raw [2];
         if (!m_run) begin
            m_ph = 1;
            if (er) begin m_run = 1; m_halt = 0; m_stop = 0; end
            else if (STEP_EN && sr) begin m_run = 1; m_halt = 0; m_stop = 1; end
         end else if (m_ph == 5) begin
            m_ph = 1;
            if (mn == M_HALT) begin m_run = 0; m_halt = 1; m_stop = 0; end
            else if (m_stop || er) begin m_run = 0; m_stop = 0; end
         end else begin
            if (er) m_stop = 1;
            if (!(m_ph == 4 && mn == M_IN && !in_valid)) m_ph = m_ph + 1;
         end
         raw[0] = exec;
         raw[1] = STEP_EN ? step_drv : 1'b0;
         for (int b = 0; b < 2; b++) begin
            automatic bit s = m_p2[b];
            if (s == m_last[b]) m_runlen[b] = (m_runlen[b] < 100000) ? m_runlen[b] + 1 : m_runlen[b];
            else m_runlen[b] = 1;
            m_last[b] = s;
            m_rise[b] = 0;
            if (m_runlen[b] >= LEN && s != m_stab[b]) begin
               m_stab[b] = s;
               m_rise[b] = s;
            end
            m_p2[b] = m_p1[b];
            m_p1[b] = raw[b];
         end
      end
   end

   function automatic logic [17:0] exp_ctrl();
      automatic mnem_e mn = mnem(instruction);
      automatic bit s = SZCV[3], z = SZCV[2], v = SZCV[0];
      automatic bit taken, wr;
      automatic logic [3:0] aop;
      taken = (mn == M_B) || (mn == M_BE && z) || (mn == M_BLT && (s != v)) ||
              (mn == M_BLE && (z || s != v)) || (mn == M_BNE && !z);
      wr = mn inside {M_LD, M_LI, M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_MOV,
                      M_SLL, M_SLR, M_SRL, M_SRA, M_IN};
      aop = (instruction[15:14] == 2'b11) ? instruction[7:4] : ((mn == M_LI) ? 4'd6 : 4'd0);
      return {m_run && m_ph == 1, m_run && m_ph == 3, m_run && m_ph == 5 && mn != M_HALT,
              m_run && m_ph == 4, mn == M_LD, instruction[15:14] == 2'b11,
              instruction[15:14] != 2'b10, instruction[15:14] == 2'b11 && instruction[7],
              m_run && m_ph == 3 && mn == M_OUT, mn == M_IN, m_run && m_ph == 4 && mn == M_ST,
              m_run && m_ph == 5 && taken, m_run && m_ph == 5 && wr, mn == M_LD || mn == M_IN,
              aop};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, #1 after the active edge.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         chk("phase", 32'(phase), 32'(1) << (m_ph - 1));
         chk("systemRunning", 32'(systemRunning), 32'(m_run));
         chk("halted", 32'(halted), 32'(m_halt));
         chk("in_ack", 32'(in_ack), 32'(m_run && m_ph == 4 && mnem(instruction) == M_IN && in_valid));
         chk("ctrl", 32'({updateIR, updateSZCV, updatePC, addressSrc, regDst, ALUSrcAR, ALUSrcBR,
                          DRSrc, outputEnable, inputEnable, memWrite, branch, regWrite, memToReg, ALUOp}),
             32'(exp_ctrl()));
      end
   end

   // ---------------- directed + random stimulus ----------------
   task automatic wait_phase(input logic [4:0] p, input string nm);
      int n = 0;
      while (phase !== p && n < 200) begin @(negedge clock); n++; end
      if (phase !== p) begin
         n_cmp++; n_fail++;
         $display("FAIL %s: phase wait timed out, got %b required %b", nm, phase, p);
      end
   endtask

   task automatic press_exec();
      exec = 1'b0; repeat (20) @(negedge clock);
      exec = 1'b1; repeat (20) @(negedge clock);
      exec = 1'b0; repeat (10) @(negedge clock);
   endtask

   initial begin
      automatic logic [4:0] ph_seq [6] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
      automatic int hold_e = 0, hold_s = 0;
      reset = 1'b0; exec = 1'b0; step_drv = 1'b0; in_valid = 1'b0;
      instruction = 16'hC000; SZCV = 4'b0000;
      repeat (4) @(negedge clock);
      chk("reset_phase", 32'(phase), 32'h01);
      chk("reset_running", 32'(systemRunning), 0);
      chk("reset_halted", 32'(halted), 0);
      chk("reset_gated", 32'({updateIR, updatePC, regWrite, in_ack}), 0);
      reset = 1'b1;
      repeat (3) @(negedge clock);

      // bouncing exec never reaches the debounce length
      for (int i = 0; i < 20; i++) begin
         exec = ~exec;
         repeat (5) @(negedge clock);
      end
      exec = 1'b0;
      chk("bounce_running", 32'(systemRunning), 0);
      repeat (20) @(negedge clock);

      // start latency: 2 sync + 16 debounce + 1 -> running after edge 19
      exec = 1'b1;
      repeat (18) @(negedge clock);
      chk("start_pre", 32'(systemRunning), 0);
      @(negedge clock);
      chk("start_running", 32'(systemRunning), 1);
      for (int i = 0; i < 6; i++) begin
         chk("start_phase_seq", 32'(phase), 32'(ph_seq[i]));
         @(negedge clock);
      end
      exec = 1'b0;

      // HALT
      wait_phase(5'b00001, "halt_p1");
      instruction = 16'hC0F0;
      wait_phase(5'b10000, "halt_p5");
      chk("halt_updatePC", 32'(updatePC), 0);
      @(negedge clock);
      chk("halt_running", 32'(systemRunning), 0);
      chk("halt_halted", 32'(halted), 1);
      chk("halt_phase", 32'(phase), 32'h01);
      instruction = 16'hC000;
      press_exec();
      chk("restart_running", 32'(systemRunning), 1);
      chk("restart_halted", 32'(halted), 0);

      // IN stall
      wait_phase(5'b00001, "in_p1");
      instruction = 16'hC0C0; in_valid = 1'b0;
      wait_phase(5'b01000, "in_p4");
      for (int i = 0; i < 10; i++) begin
         chk("in_stall_phase", 32'(phase), 32'h08);
         chk("in_stall_ack", 32'(in_ack), 0);
         @(negedge clock);
      end
      in_valid = 1'b1;
      #1 chk("in_ack_pulse", 32'(in_ack), 1);
      @(negedge clock);
      chk("in_p5_phase", 32'(phase), 32'h10);
      chk("in_p5_write", 32'({regWrite, memToReg}), 32'b11);
      in_valid = 1'b0; instruction = 16'hC000;

      // BE taken / not taken
      wait_phase(5'b00001, "be_p1");
      instruction = 16'hB800; SZCV = 4'b0100;
      wait_phase(5'b10000, "be_p5");
      chk("be_taken", 32'(branch), 1);
      wait_phase(5'b00001, "be2_p1");
      SZCV = 4'b0000;
      wait_phase(5'b10000, "be2_p5");
      chk("be_not_taken", 32'(branch), 0);
      instruction = 16'hC000;

      // stop request while running
      press_exec();
      chk("stop_running", 32'(systemRunning), 0);
      chk("stop_halted", 32'(halted), 0);

      // reset in the middle of an IN stall
      press_exec();
      wait_phase(5'b00001, "rst_p1");
      instruction = 16'hC0C0; in_valid = 1'b0;
      wait_phase(5'b01000, "rst_p4");
      repeat (3) @(negedge clock);
      #2 reset = 1'b0;
      #1;
      chk("rst_phase", 32'(phase), 32'h01);
      chk("rst_running", 32'(systemRunning), 0);
      @(negedge clock);
      reset = 1'b1;
      repeat (30) @(negedge clock);
      chk("rst_stays_stopped", 32'(systemRunning), 0);
      instruction = 16'hC000;

`ifdef CTRL_STEP_EN
      begin
         automatic int run_cyc = 0, rw_cyc = 0;
         step_drv = 1'b1;
         for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (i == 20) step_drv = 1'b0;
            run_cyc += int'(systemRunning);
            rw_cyc  += int'(regWrite);
         end
         chk("step_run_cycles", 32'(run_cyc), 5);
         chk("step_regwrite", 32'(rw_cyc), 1);
         chk("step_stopped", 32'(systemRunning), 0);
      end
`endif

      // randomized phase
      for (int c = 0; c < 3000; c++) begin
         @(negedge clock);
         if (hold_e == 0) begin exec = 1'($urandom_range(0, 1)); hold_e = $urandom_range(1, 40); end
         else hold_e--;
         if (hold_s == 0) begin step_drv = 1'($urandom_range(0, 1)); hold_s = $urandom_range(1, 40); end
         else hold_s--;
         if ($urandom_range(0, 3) == 0) begin
            automatic logic [15:0] ir = 16'($urandom);
            case ($urandom_range(0, 7))
               0: begin ir[15:14] = 2'b11; ir[7:4] = 4'b1111; end
               1: begin ir[15:14] = 2'b11; ir[7:4] = 4'b1100; end
               2: begin ir[15:11] = 5'b10111; end
               3: begin ir[15:11] = 5'b10000; end
               default: ;
            endcase
            instruction = ir;
         end
         SZCV     = 4'($urandom);
         in_valid = ($urandom_range(0, 3) != 0);
         if (c == 1500) begin #2 reset = 1'b0; #3 reset = 1'b1; end
      end
      @(negedge clock);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/control_seq.md
CONTROL_SEQ -- requirements
Module: control_seq

Interface
REQ-001 Parameter DEBOUNCE_LEN, 16, number of consecutive stable cycles required to accept a new exec/step level (range 2..65535).
REQ-002 Parameter DBW, 16, debounce counter width; SHALL satisfy 2**DBW > DEBOUNCE_LEN.
REQ-003 clock  in  1  single system clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 exec  in  1  asynchronous run/stop button; each debounced rising edge toggles run request.
REQ-006 step  in  1  asynchronous single-step button; port present only when CTRL_STEP_EN is defined.
REQ-007 instruction  in  16  current IR contents.
REQ-008 SZCV  in  4  flags {S,Z,C,V}.
REQ-009 in_valid  in  1  external input data ready.
REQ-010 in_ack  out  1  one-cycle pulse when input data is consumed.
REQ-011 phase  out  5  one-hot phase, bit0=P1 through bit4=P5.
REQ-012 systemRunning  out  1  processor executing.
REQ-013 halted  out  1  set by HALT, cleared on next start.
REQ-014 updateIR, updateSZCV, updatePC  out  1 each  register enables for P1, P3, P5.
REQ-015 addressSrc, regDst, ALUSrcAR, ALUSrcBR, DRSrc, outputEnable, inputEnable, memWrite, branch, regWrite, memToReg  out  1 each  datapath controls.
REQ-016 ALUOp  out  4  ALU operation.

Function
REQ-017 exec and step SHALL each pass a 2-FF synchroniser, then a debouncer: stable level updates only after DEBOUNCE_LEN consecutive cycles of the new synchronised level; any bounce restarts the count at 0.
REQ-018 Phase SHALL advance P1->P2->P3->P4->P5->P1 one step per clock while running; when not running, phase SHALL hold at P1.
REQ-019 Debounced exec rising edge while stopped SHALL set systemRunning on the next clock, clear halted, and start at P1.
REQ-020 Debounced exec rising edge while running SHALL latch a stop request; systemRunning SHALL clear at the end of the current P5, never mid-instruction.
REQ-021 HALT (instruction[15:14]=11, [7:4]=1111) SHALL clear systemRunning and set halted at the end of P5; updatePC SHALL be 0 in that P5.
REQ-022 IN (11, [7:4]=1100) SHALL stall in P4 until in_valid=1; in_ack SHALL pulse in that cycle; P5 SHALL follow on the next clock. A stop request during a stall SHALL wait for instruction completion.
REQ-023 updateIR=P1, updateSZCV=P3, updatePC=P5&~halt, addressSrc=P4, memWrite=P4&ST, regWrite=P5&writer-decode, branch=P5&condition; all SHALL be 0 when not running.
REQ-024 Decodes SHALL be: regDst=LD; ALUSrcAR=(15:14=11); ALUSrcBR=(15:14!=10); DRSrc=(11,bit7=1); outputEnable=P3&OUT (1101); inputEnable=IN; memToReg=LD|IN.
REQ-025 branch conditions SHALL be: B (10_100) always; BE Z; BLT S^V; BLE Z|(S^V); BNE ~Z (10_111 with cond 000..011).
REQ-026 regWrite decode SHALL cover ADD/SUB/AND/OR, XOR/MOV, shifts, IN, LD, LI (10_000).
REQ-027 ALUOp SHALL be instruction[7:4] for class 11, 0110 for LI, otherwise 0000.
REQ-028 Simultaneous HALT in P5 and pending stop request SHALL produce a single stop with halted=1.

Reset
REQ-029 On reset low: phase=00001, systemRunning=0, halted=0, in_ack=0, stop request=0, debounce counters=0, stable levels=0; all gated outputs 0.
REQ-030 Reset assertion mid-instruction or mid-stall SHALL abort immediately; after release, the block SHALL wait for a new exec edge.

Configuration
REQ-031 Macro CTRL_STEP_EN defined: step port exists; debounced step rising edge while stopped SHALL run exactly one instruction P1..P5 and then stop (HALT/IN rules apply), with step ignored while running.
REQ-032 Macro CTRL_STEP_EN undefined: no step port, no step logic; behaviour otherwise identical.

Verification
REQ-033 Reset, exec held high 16 cycles -> systemRunning=1 at cycle 17+sync; phase cycles 1,2,4,8,16.
REQ-034 exec bounce 0/1 every 5 cycles, DEBOUNCE_LEN=16 -> systemRunning stays 0.
REQ-035 IR=0xC0F0 (HALT) while running -> in P5 updatePC=0; next cycle systemRunning=0, halted=1, phase=00001.
REQ-036 IR=0xC0C0 (IN), in_valid low for 10 cycles -> phase held 01000, in_ack=1 only in the in_valid cycle, then P5 with regWrite=1, memToReg=1.
REQ-037 IR=0xB800 (BE), SZCV=0100 -> branch=1 in P5; SZCV=0000 -> branch=0.
REQ-038 With CTRL_STEP_EN, step pulse while stopped, IR=0xC000 (ADD) -> exactly 5 phase cycles, regWrite=1 once, then systemRunning=0.
